// File: rtl/arbitro_rtc_if.sv
// Bus bundle between four requesters and the single RTC driver port.
// The master side is the requesters/driver environment; the slave side is the arbiter.
interface arbitro_rtc_if;
    logic [3:0]  req;
    logic [31:0] direc_in;
    logic [31:0] dato_in;
    logic [3:0]  lea_escriba_in;
    logic [3:0]  flag_rtc_in;
    logic        siga;
    logic        tome;
    logic [3:0]  gnt;
    logic [7:0]  direc;
    logic [7:0]  dato;
    logic        lea_escriba;
    logic        flag_rtc;
    logic [3:0]  siga_out;
    logic [3:0]  tome_out;

    modport master (
        output req, direc_in, dato_in, lea_escriba_in, flag_rtc_in, siga, tome,
        input  gnt, direc, dato, lea_escriba, flag_rtc, siga_out, tome_out
    );

    modport slave (
        input  req, direc_in, dato_in, lea_escriba_in, flag_rtc_in, siga, tome,
        output gnt, direc, dato, lea_escriba, flag_rtc, siga_out, tome_out
    );
endinterface

// File: rtl/arbitro_rtc.sv
// Round-robin arbiter sharing one RTC driver among four requesters, with a
// grant-length watchdog that force-releases and masks a requester that hogs the bus.
module arbitro_rtc #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic           clk,
    input  logic           reset,
    arbitro_rtc_if.slave   bus,
    output logic           ocupado,
    output logic           timeout_err
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  winner;
    logic [1:0]  last;
    logic [1:0]  pick;
    logic [1:0]  rr_idx;
    logic        pick_valid;
    logic [3:0]  mask;
    logic [3:0]  avail;
    logic [7:0]  count;
    logic [7:0]  count_inc;
    logic        hit_timeout;
    logic        owner_req;

    assign count_inc   = (count == 8'hFF) ? count : count + 8'd1;
    assign hit_timeout = (count_inc >= TIMEOUT);
    assign owner_req   = bus.req[winner];

    // Scan from last+1 downward in offset so the closest candidate is assigned last and wins.
    always_comb begin
        pick       = 2'd0;
        pick_valid = 1'b0;
        rr_idx     = 2'd0;
        avail      = bus.req & ~mask;
        for (int k = 3; k >= 0; k--) begin
            rr_idx = 2'(last + 2'd1 + 2'(k));
            if (avail[rr_idx]) begin
                pick       = rr_idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = GRANT;
            GRANT:   if (!owner_req || hit_timeout) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner      <= 2'd0;
            last        <= 2'd3;
            mask        <= 4'b0000;
            count       <= 8'd0;
            bus.gnt     <= 4'b0000;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            mask        <= mask & bus.req;
            case (state)
                IDLE: begin
                    count <= 8'd0;
                    if (pick_valid) begin
                        winner  <= pick;
                        last    <= pick;
                        bus.gnt <= 4'(1) << pick;
                    end
                end
                GRANT: begin
                    count <= count_inc;
                    // A voluntary drop takes priority over a simultaneous watchdog hit.
                    if (!owner_req) begin
                        bus.gnt <= 4'b0000;
                    end else if (hit_timeout) begin
                        bus.gnt     <= 4'b0000;
                        timeout_err <= 1'b1;
                        mask        <= (mask & bus.req) | (4'(1) << winner);
                    end
                end
                default: begin
                    count   <= 8'd0;
                    bus.gnt <= 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        bus.direc       = 8'h00;
        bus.dato        = 8'h00;
        bus.lea_escriba = 1'b0;
        bus.flag_rtc    = 1'b0;
        bus.siga_out    = 4'b1111;
        bus.tome_out    = 4'b0000;
        ocupado         = (state != IDLE);
        if (state == GRANT) begin
            bus.direc            = bus.direc_in[{winner, 3'b000} +: 8];
            bus.dato             = bus.dato_in[{winner, 3'b000} +: 8];
            bus.lea_escriba      = bus.lea_escriba_in[winner];
            bus.flag_rtc         = bus.flag_rtc_in[winner];
            bus.siga_out[winner] = bus.siga;
            bus.tome_out[winner] = bus.tome;
        end
    end

endmodule

// File: tb/tb_arbitro_rtc.sv
// Directed bench for arbitro_rtc: reset, routing, round-robin order, watchdog and mask,
// simultaneous drop/timeout, asynchronous reset mid-grant.
module tb_arbitro_rtc;

    logic clk;
    logic reset;
    logic ocupado;
    logic timeout_err;
    int   errors;
    int   checks;
    int   order [5];
    logic [3:0] rq;
    int   w;

    arbitro_rtc_if bus_if ();

    arbitro_rtc #(.TIMEOUT(8'd10)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .ocupado     (ocupado),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic s, input logic t);
        bus_if.req  = r;
        bus_if.siga = s;
        bus_if.tome = t;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        order  = '{0, 1, 2, 3, 0};
        reset  = 1'b0;
        bus_if.req            = 4'b0000;
        bus_if.direc_in       = 32'hD3C2B1A0;
        bus_if.dato_in        = 32'h40302010;
        bus_if.lea_escriba_in = 4'b1010;
        bus_if.flag_rtc_in    = 4'b0110;
        bus_if.siga           = 1'b1;
        bus_if.tome           = 1'b0;

        #1;
        checkOutput("rst_gnt", 32'(bus_if.gnt), 32'h0);
        checkOutput("rst_ocupado", 32'(ocupado), 32'h0);
        checkOutput("rst_siga_out", 32'(bus_if.siga_out), 32'hF);
        checkOutput("rst_tome_out", 32'(bus_if.tome_out), 32'h0);
        checkOutput("rst_direc", 32'(bus_if.direc), 32'h0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
        #11 reset = 1'b1;
        tick(1);

        $display("[TB] single requester 0");
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("r0_gnt_before_edge", 32'(bus_if.gnt), 32'h0);
        tick(1);
        checkOutput("r0_gnt", 32'(bus_if.gnt), 32'h1);
        checkOutput("r0_ocupado", 32'(ocupado), 32'h1);
        checkOutput("r0_direc", 32'(bus_if.direc), 32'hA0);
        checkOutput("r0_dato", 32'(bus_if.dato), 32'h10);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("r0_siga_out", 32'(bus_if.siga_out), 32'hE);
        checkOutput("r0_tome_out", 32'(bus_if.tome_out), 32'h1);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("r0_siga_out_hi", 32'(bus_if.siga_out), 32'hF);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(1);
        checkOutput("r0_rel_gnt", 32'(bus_if.gnt), 32'h0);
        checkOutput("r0_rel_ocupado", 32'(ocupado), 32'h1);
        checkOutput("r0_rel_direc", 32'(bus_if.direc), 32'h0);
        tick(1);
        checkOutput("r0_idle_ocupado", 32'(ocupado), 32'h0);

        $display("[TB] round robin");
        reset = 1'b0;
        #2 reset = 1'b1;
        applyStimulus(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w = order[i];
            for (int c = 1; c <= 3; c++) begin
                tick(1);
                checkOutput($sformatf("rr%0d_gnt_c%0d", i, c), 32'(bus_if.gnt), 32'(4'(1) << w));
            end
            rq = 4'b1111;
            rq[w] = 1'b0;
            applyStimulus(rq, 1'b1, 1'b0);
            tick(1);
            checkOutput($sformatf("rr%0d_rel_gnt", i), 32'(bus_if.gnt), 32'h0);
            checkOutput($sformatf("rr%0d_rel_ocupado", i), 32'(ocupado), 32'h1);
            applyStimulus(4'b1111, 1'b1, 1'b0);
            tick(1);
            checkOutput($sformatf("rr%0d_idle_gnt", i), 32'(bus_if.gnt), 32'h0);
            checkOutput($sformatf("rr%0d_idle_ocupado", i), 32'(ocupado), 32'h0);
        end
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(1);

        $display("[TB] watchdog on requester 2");
        applyStimulus(4'b0100, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checkOutput($sformatf("to_gnt_c%0d", k), 32'(bus_if.gnt), 32'h4);
        end
        checkOutput("to_err_before", 32'(timeout_err), 32'h0);
        tick(1);
        checkOutput("to_rel_gnt", 32'(bus_if.gnt), 32'h0);
        checkOutput("to_err_pulse", 32'(timeout_err), 32'h1);
        checkOutput("to_rel_ocupado", 32'(ocupado), 32'h1);
        tick(1);
        checkOutput("to_err_cleared", 32'(timeout_err), 32'h0);
        checkOutput("to_masked_gnt1", 32'(bus_if.gnt), 32'h0);
        tick(1);
        checkOutput("to_masked_gnt2", 32'(bus_if.gnt), 32'h0);
        checkOutput("to_masked_ocupado", 32'(ocupado), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(1);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        tick(1);
        checkOutput("to_regrant", 32'(bus_if.gnt), 32'h4);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(2);

        $display("[TB] drop coinciding with watchdog on requester 1");
        applyStimulus(4'b0010, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checkOutput($sformatf("dr_gnt_c%0d", k), 32'(bus_if.gnt), 32'h2);
            if (k == 1) begin
                checkOutput("dr_direc", 32'(bus_if.direc), 32'hB1);
                checkOutput("dr_dato", 32'(bus_if.dato), 32'h20);
                checkOutput("dr_lea", 32'(bus_if.lea_escriba), 32'h1);
                checkOutput("dr_flag", 32'(bus_if.flag_rtc), 32'h1);
            end
        end
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(1);
        checkOutput("dr_rel_gnt", 32'(bus_if.gnt), 32'h0);
        checkOutput("dr_no_err", 32'(timeout_err), 32'h0);
        checkOutput("dr_rel_ocupado", 32'(ocupado), 32'h1);
        tick(1);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        tick(1);
        checkOutput("dr_regrant", 32'(bus_if.gnt), 32'h2);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(2);

        $display("[TB] routing for requester 3");
        applyStimulus(4'b1000, 1'b1, 1'b0);
        tick(1);
        checkOutput("r3_gnt", 32'(bus_if.gnt), 32'h8);
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkOutput("r3_tome_out", 32'(bus_if.tome_out), 32'h8);
        checkOutput("r3_siga_out", 32'(bus_if.siga_out), 32'h7);
        checkOutput("r3_direc", 32'(bus_if.direc), 32'hD3);
        checkOutput("r3_dato", 32'(bus_if.dato), 32'h40);
        checkOutput("r3_lea", 32'(bus_if.lea_escriba), 32'h1);
        checkOutput("r3_flag", 32'(bus_if.flag_rtc), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("r3_rel_tome_out", 32'(bus_if.tome_out), 32'h0);
        checkOutput("r3_rel_siga_out", 32'(bus_if.siga_out), 32'hF);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        tick(1);

        $display("[TB] asynchronous reset during grant of requester 2");
        applyStimulus(4'b0100, 1'b1, 1'b0);
        tick(1);
        checkOutput("ar_gnt", 32'(bus_if.gnt), 32'h4);
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_gnt_dropped", 32'(bus_if.gnt), 32'h0);
        checkOutput("ar_ocupado", 32'(ocupado), 32'h0);
        checkOutput("ar_direc", 32'(bus_if.direc), 32'h0);
        bus_if.req = 4'b1111;
        reset = 1'b1;
        tick(1);
        checkOutput("ar_first_gnt", 32'(bus_if.gnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
